// File: rtl/crypto_core_driver.sv
// crypto_core_driver: initiator-side sequencer for the 16-bit crypto core.
// Accepts one encrypt/decrypt command and presents key/data/mode to the core.
// Holds the core begin strobe for BGN_CYCLES cycles, then waits for the core
// finish flag, bounded by TIMEOUT cycles. Returns the captured data/key result,
// or an error response, over a valid/ready handshake.
module crypto_core_driver #(
   parameter int BGN_CYCLES = 4,
   parameter int TIMEOUT    = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_key,
   input  logic [15:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic [15:0] rsp_key,
   output logic        rsp_err,
   output logic [1:0]  core_mode,
   output logic [15:0] core_key,
   output logic [15:0] core_data,
   output logic        core_bgn,
   input  logic        core_fin,
   input  logic [15:0] core_key_res,
   input  logic [15:0] core_data_res,
   output logic        busy,
   output logic [7:0]  done_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [3:0] BGN_LAST = 4'(BGN_CYCLES);
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT);

   state_t      state_q;
   logic [3:0]  bgn_cnt_q;
   logic [7:0]  wait_cnt_q;
   logic [7:0]  wait_cnt_d;
   logic        cmd_ready_q;
   logic        rsp_valid_q;
   logic [15:0] rsp_data_q;
   logic [15:0] rsp_key_q;
   logic        rsp_err_q;
   logic [1:0]  core_mode_q;
   logic [15:0] core_key_q;
   logic [15:0] core_data_q;
   logic        core_bgn_q;
   logic        busy_q;
   logic [7:0]  done_count_q;
   logic        op_legal;

   // Saturating increment so internal counters never wrap.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // Legal ops are 01 and 10, exactly the codes whose bits differ.
   assign op_legal = cmd_op[0] ^ cmd_op[1];

   // Next value of the WAIT-cycle counter, counting the cycle being sampled.
   always_comb begin
      wait_cnt_d = sat_inc8(wait_cnt_q);
   end

   // Control FSM; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bgn_cnt_q    <= 4'd0;
         wait_cnt_q   <= 8'd0;
         cmd_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= 16'd0;
         rsp_key_q    <= 16'd0;
         rsp_err_q    <= 1'b0;
         core_mode_q  <= 2'd0;
         core_key_q   <= 16'd0;
         core_data_q  <= 16'd0;
         core_bgn_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_count_q <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (op_legal) begin
                     state_q     <= LAUNCH;
                     core_mode_q <= cmd_op;
                     core_key_q  <= cmd_key;
                     core_data_q <= cmd_data;
                     core_bgn_q  <= 1'b1;
                     bgn_cnt_q   <= 4'd1;
                  end else begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= 16'd0;
                     rsp_key_q   <= 16'd0;
                  end
               end
            end

            LAUNCH: begin
               // core_fin is deliberately not looked at while begin is held.
               if (bgn_cnt_q >= BGN_LAST) begin
                  core_bgn_q <= 1'b0;
                  wait_cnt_q <= 8'd0;
                  state_q    <= WAIT;
               end else begin
                  bgn_cnt_q <= sat_inc4(bgn_cnt_q);
               end
            end

            WAIT: begin
               // A finish in the very cycle the limit is hit still counts as success.
               if (core_fin) begin
                  rsp_data_q  <= core_data_res;
                  rsp_key_q   <= core_key_res;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else if (wait_cnt_d >= TO_LAST) begin
                  rsp_data_q  <= 16'd0;
                  rsp_key_q   <= 16'd0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_d;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  if (!rsp_err_q) begin
                     done_count_q <= done_count_q + 8'd1;
                  end
                  rsp_valid_q <= 1'b0;
                  rsp_data_q  <= 16'd0;
                  rsp_key_q   <= 16'd0;
                  rsp_err_q   <= 1'b0;
                  core_mode_q <= 2'd0;
                  core_key_q  <= 16'd0;
                  core_data_q <= 16'd0;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_key    = rsp_key_q;
   assign rsp_err    = rsp_err_q;
   assign core_mode  = core_mode_q;
   assign core_key   = core_key_q;
   assign core_data  = core_data_q;
   assign core_bgn   = core_bgn_q;
   assign busy       = busy_q;
   assign done_count = done_count_q;

endmodule

// File: tb/tb_crypto_core_driver.sv
// Testbench for crypto_core_driver. It uses directed transactions plus a
// randomized burst. Expected responses come from the command/fin timing rules:
// legal op, fin within the window, and a modulo-256 completion count.
module tb_crypto_core_driver;

   localparam int BGN = 4;
   localparam int TO  = 200;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_key;
   logic [15:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [15:0] rsp_key;
   logic        rsp_err;
   logic [1:0]  core_mode;
   logic [15:0] core_key;
   logic [15:0] core_data;
   logic        core_bgn;
   logic        core_fin;
   logic [15:0] core_key_res;
   logic [15:0] core_data_res;
   logic        busy;
   logic [7:0]  done_count;

   int total = 0;
   int bad   = 0;
   int exp_done = 0;

   always #5 clk = ~clk;

   crypto_core_driver #(.BGN_CYCLES(BGN), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_key(cmd_key), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_key(rsp_key), .rsp_err(rsp_err),
      .core_mode(core_mode), .core_key(core_key), .core_data(core_data),
      .core_bgn(core_bgn), .core_fin(core_fin),
      .core_key_res(core_key_res), .core_data_res(core_data_res),
      .busy(busy), .done_count(done_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transaction, entered and left at a falling edge with the driver idle.
   // fin_at: WAIT cycle (1-based) on which core_fin is high, 0 = never.
   // lf: LAUNCH cycle (1-based) on which a stray fin pulse is injected, 0 = none.
   // hold: cycles rsp_ready stays low after rsp_valid is seen.
   // pend: during the hold, present the next command (pop/pkey/pdata) early.
   task automatic txn(input string tag, input logic [1:0] op, input logic [15:0] key,
                      input logic [15:0] data, input int fin_at, input int lf, input int hold,
                      input logic [15:0] dres, input logic [15:0] kres,
                      input bit pend, input logic [1:0] pop, input logic [15:0] pkey,
                      input logic [15:0] pdata);
      bit          legal;
      bit          exp_err;
      int          exp_n;
      int          c;
      int          n;
      logic [15:0] ed;
      logic [15:0] ek;
      legal   = (op == 2'b01) || (op == 2'b10);
      exp_err = !legal || (fin_at < 1) || (fin_at > TO);
      exp_n   = (fin_at >= 1 && fin_at <= TO) ? fin_at : TO;
      ed      = exp_err ? 16'h0000 : dres;
      ek      = exp_err ? 16'h0000 : kres;

      chk({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_key   = key;
      cmd_data  = data;
      rsp_ready = (hold == 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_key   = 16'h0000;
      cmd_data  = 16'h0000;
      chk({tag, "_acc_ready"}, 32'(cmd_ready), 32'd0);
      chk({tag, "_acc_busy"}, 32'(busy), 32'd1);

      if (legal) begin
         c = 0;
         core_data_res = 16'hDEAD;
         core_key_res  = 16'hBEEF;
         while (core_bgn === 1'b1 && c < 20) begin
            c++;
            chk({tag, "_l_mode"}, 32'(core_mode), 32'(op));
            chk({tag, "_l_key"}, 32'(core_key), 32'(key));
            chk({tag, "_l_data"}, 32'(core_data), 32'(data));
            core_fin = (c == lf);
            @(negedge clk);
         end
         core_fin = 1'b0;
         chk({tag, "_bgn_len"}, 32'(c), 32'(BGN));
         core_data_res = dres;
         core_key_res  = kres;
         n = 0;
         while (rsp_valid !== 1'b1 && n < TO + 20) begin
            n++;
            core_fin = (n == fin_at);
            @(negedge clk);
         end
         core_fin = 1'b0;
         chk({tag, "_wait_len"}, 32'(n), 32'(exp_n));
         chk({tag, "_w_bgn"}, 32'(core_bgn), 32'd0);
      end else begin
         chk({tag, "_no_bgn"}, 32'(core_bgn), 32'd0);
      end

      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(ed));
      chk({tag, "_rsp_key"}, 32'(rsp_key), 32'(ek));
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, "_rsp_mode"}, 32'(core_mode), legal ? 32'(op) : 32'd0);

      if (hold > 0) begin
         if (pend) begin
            cmd_valid = 1'b1;
            cmd_op    = pop;
            cmd_key   = pkey;
            cmd_data  = pdata;
         end
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(rsp_data), 32'(ed));
            chk({tag, "_hold_key"}, 32'(rsp_key), 32'(ek));
            chk({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
            chk({tag, "_hold_ready"}, 32'(cmd_ready), 32'd0);
            chk({tag, "_hold_mode"}, 32'(core_mode), legal ? 32'(op) : 32'd0);
         end
         rsp_ready = 1'b1;
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      if (!exp_err) exp_done = (exp_done + 1) % 256;
      chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_post_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_post_busy"}, 32'(busy), 32'd0);
      chk({tag, "_post_mode"}, 32'(core_mode), 32'd0);
      chk({tag, "_done_count"}, 32'(done_count), 32'(exp_done));
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = 2'b00;
      cmd_key = 16'h0000;
      cmd_data = 16'h0000;
      rsp_ready = 1'b0;
      core_fin = 1'b0;
      core_key_res = 16'h0000;
      core_data_res = 16'h0000;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_bgn", 32'(core_bgn), 32'd0);
      chk("rst_done", 32'(done_count), 32'd0);
      chk("rst_mode", 32'(core_mode), 32'd0);
      rst = 1'b0;
      exp_done = 0;
      @(negedge clk);

      // Encrypt, 1-cycle response
      txn("enc", 2'b01, 16'h1325, 16'h59B3, 20, 0, 0, 16'hABCD, 16'h1234, 1'b0, 2'b00, 16'h0, 16'h0);

      // Decrypt with back-pressure; the next command waits until after the handshake
      txn("dec", 2'b10, 16'hA058, 16'h47E9, 7, 0, 5, 16'h5A5A, 16'hC3C3, 1'b1, 2'b01, 16'h0F0F, 16'hF0F0);
      txn("pend", 2'b01, 16'h0F0F, 16'hF0F0, 3, 0, 0, 16'h7777, 16'h8888, 1'b0, 2'b00, 16'h0, 16'h0);

      // Illegal ops
      txn("ill11", 2'b11, 16'hFFFF, 16'h1111, 5, 0, 0, 16'h9999, 16'h9999, 1'b0, 2'b00, 16'h0, 16'h0);
      txn("ill00", 2'b00, 16'h2222, 16'h3333, 5, 0, 2, 16'h9999, 16'h9999, 1'b0, 2'b00, 16'h0, 16'h0);

      // Timeout, then fin on the last permitted WAIT cycle
      txn("tmo", 2'b01, 16'h4444, 16'h5555, 0, 0, 0, 16'h6666, 16'h7777, 1'b0, 2'b00, 16'h0, 16'h0);
      txn("fin_last", 2'b10, 16'h4444, 16'h5555, TO, 0, 0, 16'hCAFE, 16'hF00D, 1'b0, 2'b00, 16'h0, 16'h0);

      // Reset in the middle of WAIT
      cmd_valid = 1'b1;
      cmd_op = 2'b01;
      cmd_key = 16'h1357;
      cmd_data = 16'h2468;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op = 2'b00;
      repeat (BGN + 3) @(negedge clk);
      chk("mid_wait_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_done = 0;
      chk("rstw_busy", 32'(busy), 32'd0);
      chk("rstw_ready", 32'(cmd_ready), 32'd1);
      chk("rstw_valid", 32'(rsp_valid), 32'd0);
      chk("rstw_bgn", 32'(core_bgn), 32'd0);
      chk("rstw_done", 32'(done_count), 32'd0);
      chk("rstw_mode", 32'(core_mode), 32'd0);
      txn("after_rst", 2'b01, 16'hAAAA, 16'h5555, 4, 0, 0, 16'h0123, 16'h4567, 1'b0, 2'b00, 16'h0, 16'h0);

      // 256 back-to-back random encrypts with stray launch-time fin pulses
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_done = 0;
      for (int i = 0; i < 256; i++) begin
         txn("burst", 2'b01, 16'($urandom), 16'($urandom), int'($urandom_range(1, 6)),
             (i % 8 == 0) ? int'($urandom_range(1, BGN)) : 0, 0,
             16'($urandom), 16'($urandom), 1'b0, 2'b00, 16'h0, 16'h0);
      end
      chk("wrap_done", 32'(done_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
